// File: rtl/alu_control_seq.sv
// Registered ALU control decode with multi-cycle mult/div sequencing and a stall handshake.
// Optional sticky illegal-op trap is enabled by defining ALUCTL_ILLEGAL_TRAP_EN.
module alu_control_seq #(
    parameter int unsigned CTRL_W    = 4,
    parameter int unsigned MD_CYCLES = 32,
    parameter int unsigned CNT_W     = $clog2(MD_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
`ifdef ALUCTL_ILLEGAL_TRAP_EN
    input  logic              illegal_clr,
    output logic              illegal_sticky,
`endif
    input  logic              in_valid,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        Function,
    output logic [CTRL_W-1:0] ALU_Control,
    output logic              JRControl,
    output logic              out_valid,
    output logic              md_start,
    output logic              md_done,
    output logic              stall,
    output logic              illegal
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       alu_ctrl_q, dec_ctrl;
    logic             jr_q, dec_jr;
    logic             illegal_q, dec_illegal;
    logic             out_valid_q;
    logic             dec_md;
    logic             accept;
    logic             md_launch;

    // Unknown ALUOp/Function fall through to the default arms and decode as illegal.
    always_comb begin
        dec_ctrl    = 4'b0000;
        dec_jr      = 1'b0;
        dec_illegal = 1'b0;
        dec_md      = 1'b0;
        case (ALUOp)
            2'b00: dec_ctrl = 4'b0010;
            2'b01: dec_ctrl = 4'b0110;
            2'b10: begin
                case (Function)
                    6'b100000: dec_ctrl = 4'b0010;
                    6'b100010: dec_ctrl = 4'b0110;
                    6'b100100: dec_ctrl = 4'b0000;
                    6'b100101: dec_ctrl = 4'b0001;
                    6'b100111: dec_ctrl = 4'b1100;
                    6'b101010: dec_ctrl = 4'b0111;
                    6'b001000: begin
                        dec_ctrl = 4'b0010;
                        dec_jr   = 1'b1;
                    end
                    6'b011000: begin
                        dec_ctrl = 4'b1000;
                        dec_md   = 1'b1;
                    end
                    6'b011010: begin
                        dec_ctrl = 4'b1001;
                        dec_md   = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign accept = in_valid && (state_q == StIdle);

`ifdef ALUCTL_ILLEGAL_TRAP_EN
    logic sticky_q;

    // A trapped unit still reports mult/div codes but never launches the mul-div unit.
    assign md_launch = accept && dec_md && !sticky_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (accept && dec_illegal) begin
            sticky_q <= 1'b1;
        end else if (illegal_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign illegal_sticky = sticky_q;
`else
    assign md_launch = accept && dec_md;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            alu_ctrl_q  <= 4'b0000;
            jr_q        <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= accept;
            if (accept) begin
                alu_ctrl_q <= dec_ctrl;
                jr_q       <= dec_jr;
                illegal_q  <= dec_illegal;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (md_launch) begin
                    state_d = StBusy;
                    cnt_d   = CNT_W'(MD_CYCLES - 1);
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; the first busy cycle is the only one holding MD_CYCLES-1.
    always_comb begin
        stall       = (state_q == StBusy);
        md_start    = (state_q == StBusy) && (cnt_q == CNT_W'(MD_CYCLES - 1));
        md_done     = (state_q == StBusy) && (cnt_q == '0);
        out_valid   = out_valid_q;
        JRControl   = jr_q;
        illegal     = illegal_q;
        ALU_Control = CTRL_W'(alu_ctrl_q);
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed, table-driven bench for alu_control_seq with MD_CYCLES=4.
module tb_alu_control_seq;

    localparam int unsigned CTRL_W    = 4;
    localparam int unsigned MD_CYCLES = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [1:0]        ALUOp;
    logic [5:0]        Function;
    logic [CTRL_W-1:0] ALU_Control;
    logic              JRControl;
    logic              out_valid;
    logic              md_start;
    logic              md_done;
    logic              stall;
    logic              illegal;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
    logic              illegal_clr;
    logic              illegal_sticky;
`endif

    int errors = 0;
    int checks = 0;

    alu_control_seq #(
        .CTRL_W   (CTRL_W),
        .MD_CYCLES(MD_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef ALUCTL_ILLEGAL_TRAP_EN
        .illegal_clr   (illegal_clr),
        .illegal_sticky(illegal_sticky),
`endif
        .in_valid      (in_valid),
        .ALUOp         (ALUOp),
        .Function      (Function),
        .ALU_Control   (ALU_Control),
        .JRControl     (JRControl),
        .out_valid     (out_valid),
        .md_start      (md_start),
        .md_done       (md_done),
        .stall         (stall),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] ctrl;
        logic       jr;
        logic       ill;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pipe(input string tag, input int ov, input int st, input int ms,
                              input int md);
        check({tag, "_out_valid"}, int'(out_valid), ov);
        check({tag, "_stall"}, int'(stall), st);
        check({tag, "_md_start"}, int'(md_start), ms);
        check({tag, "_md_done"}, int'(md_done), md);
    endtask

    initial begin
        vecs[0]  = '{2'b10, 6'b100100, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{2'b00, 6'b111111, 4'b0010, 1'b0, 1'b0};
        vecs[2]  = '{2'b01, 6'b000000, 4'b0110, 1'b0, 1'b0};
        vecs[3]  = '{2'b10, 6'b100000, 4'b0010, 1'b0, 1'b0};
        vecs[4]  = '{2'b10, 6'b100010, 4'b0110, 1'b0, 1'b0};
        vecs[5]  = '{2'b10, 6'b100101, 4'b0001, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 6'b100111, 4'b1100, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 6'b101010, 4'b0111, 1'b0, 1'b0};
        vecs[8]  = '{2'b10, 6'b111111, 4'b0000, 1'b0, 1'b1};
        vecs[9]  = '{2'b11, 6'b100000, 4'b0000, 1'b0, 1'b1};
        vecs[10] = '{2'b11, 6'b011000, 4'b0000, 1'b0, 1'b1};
        vecs[11] = '{2'b10, 6'b001000, 4'b0010, 1'b1, 1'b0};

        reset    = 1'b1;
        in_valid = 1'b0;
        ALUOp    = 2'b00;
        Function = 6'b000000;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
        illegal_clr = 1'b0;
`endif
        step();
        step();
        check("rst_ctrl", int'(ALU_Control), 0);
        check("rst_jr", int'(JRControl), 0);
        check("rst_illegal", int'(illegal), 0);
        check_pipe("rst", 0, 0, 0, 0);
        reset = 1'b0;

        // Single-cycle decodes, applied back to back.
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            ALUOp    = vecs[i].op;
            Function = vecs[i].fn;
            step();
            check($sformatf("v%0d_ctrl", i), int'(ALU_Control), int'(vecs[i].ctrl));
            check($sformatf("v%0d_jr", i), int'(JRControl), int'(vecs[i].jr));
            check($sformatf("v%0d_illegal", i), int'(illegal), int'(vecs[i].ill));
            check_pipe($sformatf("v%0d", i), 1, 0, 0, 0);
        end

        // Idle cycle: outputs hold, out_valid drops.
        in_valid = 1'b0;
        step();
        check("hold_ctrl", int'(ALU_Control), 2);
        check("hold_jr", int'(JRControl), 1);
        check_pipe("hold", 0, 0, 0, 0);

        // DIV, then an add held during the stall.
        in_valid = 1'b1;
        ALUOp    = 2'b10;
        Function = 6'b011010;
        step();
        check("div_ctrl", int'(ALU_Control), 9);
        check("div_jr", int'(JRControl), 0);
        check_pipe("div_c1", 1, 1, 1, 0);
        ALUOp    = 2'b00;
        Function = 6'b000000;
        step();
        check_pipe("div_c2", 0, 1, 0, 0);
        step();
        check_pipe("div_c3", 0, 1, 0, 0);
        check("div_c3_ctrl", int'(ALU_Control), 9);
        step();
        check_pipe("div_c4", 0, 1, 0, 1);
        step();
        check_pipe("div_c5", 0, 0, 0, 0);
        step();
        check_pipe("div_add", 1, 0, 0, 0);
        check("div_add_ctrl", int'(ALU_Control), 2);
        in_valid = 1'b0;
        step();

        // MULT with reset asserted in the 2nd busy cycle.
        in_valid = 1'b1;
        ALUOp    = 2'b10;
        Function = 6'b011000;
        step();
        check("mul_ctrl", int'(ALU_Control), 8);
        check_pipe("mul_c1", 1, 1, 1, 0);
        in_valid = 1'b0;
        step();
        check_pipe("mul_c2", 0, 1, 0, 0);
        reset = 1'b1;
        step();
        check("mrst_ctrl", int'(ALU_Control), 0);
        check("mrst_jr", int'(JRControl), 0);
        check("mrst_illegal", int'(illegal), 0);
        check_pipe("mrst", 0, 0, 0, 0);
        reset    = 1'b0;
        in_valid = 1'b1;
        ALUOp    = 2'b01;
        step();
        check("post_rst_ctrl", int'(ALU_Control), 6);
        check_pipe("post_rst", 1, 0, 0, 0);
        in_valid = 1'b0;
        step();
        check_pipe("post_rst_idle", 0, 0, 0, 0);

`ifdef ALUCTL_ILLEGAL_TRAP_EN
        in_valid = 1'b1;
        ALUOp    = 2'b11;
        Function = 6'b000000;
        step();
        check("trap_set", int'(illegal_sticky), 1);
        for (int i = 0; i < 3; i++) begin
            ALUOp    = 2'b10;
            Function = (i == 1) ? 6'b100101 : 6'b100000;
            step();
            check($sformatf("trap_hold%0d", i), int'(illegal_sticky), 1);
            check($sformatf("trap_hold%0d_ill", i), int'(illegal), 0);
        end
        in_valid    = 1'b0;
        illegal_clr = 1'b1;
        step();
        check("trap_clr", int'(illegal_sticky), 0);
        // Set beats clear in the same cycle.
        in_valid = 1'b1;
        ALUOp    = 2'b10;
        Function = 6'b111111;
        step();
        check("trap_set_wins", int'(illegal_sticky), 1);
        illegal_clr = 1'b0;
        Function    = 6'b011000;
        step();
        check("trap_mul_ctrl", int'(ALU_Control), 8);
        check_pipe("trap_mul", 1, 0, 0, 0);
        in_valid    = 1'b0;
        illegal_clr = 1'b1;
        step();
        check("trap_clr2", int'(illegal_sticky), 0);
        illegal_clr = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
